// File: rtl/bcd_sanitize_sequencer_if.sv
// bcd_sanitize_sequencer_if: input and output valid/ready channels of the BCD sanitizer.
interface bcd_sanitize_sequencer_if #(parameter int DIGITS = 300);
    localparam int CW = $clog2(DIGITS + 1);
    logic                in_valid;
    logic                in_ready;
    logic [4*DIGITS-1:0] in_bcd;
    logic                out_valid;
    logic                out_ready;
    logic [4*DIGITS-1:0] out_dec;
    logic [CW-1:0]       out_err_count;
    logic                out_err;
    modport master(output in_valid, in_bcd, out_ready,
                   input in_ready, out_valid, out_dec, out_err_count, out_err);
    modport slave(input in_valid, in_bcd, out_ready,
                  output in_ready, out_valid, out_dec, out_err_count, out_err);
endinterface

// File: rtl/bcd_sanitize_sequencer.sv
// bcd_sanitize_sequencer: walks a wide BCD word CHUNK digits per cycle, zeroing and counting digits above 9.
module bcd_sanitize_sequencer #(
    parameter int DIGITS = 300,
    parameter int CHUNK  = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    bcd_sanitize_sequencer_if.slave   bus,
    output logic                      busy
);
    localparam int NCHUNK = DIGITS / CHUNK;
    localparam int CW     = $clog2(DIGITS + 1);
    localparam int IW     = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    localparam int CB     = 4 * CHUNK;

    if (DIGITS % CHUNK != 0) begin : g_bad_chunk
        $error("DIGITS must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_nx;
    logic [4*DIGITS-1:0] shadow, dec;
    logic [CW-1:0]       cnt, chunk_err;
    logic [IW-1:0]       idx;
    logic [CB-1:0]       chunk_in, chunk_out;

    assign chunk_in = shadow[int'(idx)*CB +: CB];

    always_comb begin
        chunk_out = '0;
        chunk_err = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_out[4*i +: 4] = chunk_in[4*i +: 4] > 4'd9 ? 4'd0 : chunk_in[4*i +: 4];
            chunk_err = chunk_err + CW'(chunk_in[4*i +: 4] > 4'd9);
        end
    end

    always_comb begin
        state_nx = state == IDLE ? (bus.in_valid ? RUN : IDLE)
                 : state == RUN  ? (idx == IW'(NCHUNK - 1) ? DONE : RUN)
                 : (bus.out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            shadow <= '0;
            dec    <= '0;
            cnt    <= '0;
            idx    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.in_valid) begin
                shadow <= bus.in_bcd;
                dec    <= '0;
                cnt    <= '0;
                idx    <= '0;
            end else if (state == RUN) begin
                dec[int'(idx)*CB +: CB] <= chunk_out;
                cnt <= cnt + chunk_err;
                idx <= idx + 1'b1;
            end
        end
    end

    assign bus.in_ready      = state == IDLE;
    assign bus.out_valid     = state == DONE;
    assign bus.out_dec       = dec;
    assign bus.out_err_count = cnt;
    assign bus.out_err       = |cnt;
    assign busy              = state != IDLE;
endmodule

// File: tb/tb_bcd_sanitize_sequencer.sv
// tb_bcd_sanitize_sequencer: directed checks of the BCD sanitizer with hand-built expected words.
module tb_bcd_sanitize_sequencer;
    localparam int D = 300;
    localparam int W = 4 * D;

    logic clk = 0;
    logic reset;
    logic busy;
    int   n_assert = 0;
    int   n_fail = 0;
    int   lat;
    logic [W-1:0] w, e, w2, e2;

    bcd_sanitize_sequencer_if #(.DIGITS(D)) bus ();

    bcd_sanitize_sequencer #(.DIGITS(D), .CHUNK(20)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] fill(input logic [3:0] d);
        logic [W-1:0] r;
        for (int i = 0; i < D; i++) r[4*i +: 4] = d;
        return r;
    endfunction

    task automatic send(input logic [W-1:0] word);
        int t;
        t = 0;
        bus.in_bcd = word;
        bus.in_valid = 1;
        while (!bus.in_ready && t < 40) begin
            step();
            t++;
        end
        chk("accept_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic result(input string tag, input logic [W-1:0] exp, input int ec);
        chk({tag, "_lat"}, lat, 15);
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_dec"}, bus.out_dec, exp);
        chk({tag, "_cnt"}, bus.out_err_count, ec);
        chk({tag, "_err"}, bus.out_err, ec != 0);
        chk({tag, "_noready"}, bus.in_ready, 0);
    endtask

    initial begin
        reset = 1;
        bus.in_valid = 0;
        bus.in_bcd = '0;
        bus.out_ready = 0;
        step();
        step();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dec", bus.out_dec, 0);
        chk("rst_cnt", bus.out_err_count, 0);
        chk("rst_err", bus.out_err, 0);
        reset = 0;
        bus.out_ready = 1;

        // all nines pass through untouched
        send(fill(4'h9));
        chk("t1_busy", busy, 1);
        chk("t1_run_ready", bus.in_ready, 0);
        wait_out(lat);
        result("t1", fill(4'h9), 0);
        step();
        chk("t1_idle_ready", bus.in_ready, 1);
        chk("t1_hold_dec", bus.out_dec, fill(4'h9));

        send(fill(4'hA));
        wait_out(lat);
        result("t2", '0, 300);
        step();

        w = fill(4'h5);
        w[3:0] = 4'hF;
        w[W-1 -: 4] = 4'hA;
        e = fill(4'h5);
        e[3:0] = 4'h0;
        e[W-1 -: 4] = 4'h0;
        send(w);
        wait_out(lat);
        result("t3", e, 2);
        step();

        // backpressure: result must hold while new traffic is offered
        bus.out_ready = 0;
        w = fill(4'h3);
        w[4*150 +: 4] = 4'hB;
        e = fill(4'h3);
        e[4*150 +: 4] = 4'h0;
        send(w);
        wait_out(lat);
        result("t4", e, 1);
        bus.in_valid = 1;
        bus.in_bcd = fill(4'h7);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t4_stable_dec", bus.out_dec, e);
            chk("t4_stable_cnt", bus.out_err_count, 1);
            chk("t4_stable_ready", bus.in_ready, 0);
            chk("t4_stable_valid", bus.out_valid, 1);
        end
        bus.in_valid = 0;
        bus.out_ready = 1;
        step();
        chk("t4_released", bus.out_valid, 0);
        chk("t4_keep_dec", bus.out_dec, e);
        chk("t4_idle", busy, 0);

        // reset in the middle of RUN, with errors already counted
        send(fill(4'hC));
        repeat (7) step();
        chk("t5_pre_cnt", bus.out_err_count, 140);
        reset = 1;
        step();
        reset = 0;
        chk("t5_in_ready", bus.in_ready, 1);
        chk("t5_busy", busy, 0);
        chk("t5_out_valid", bus.out_valid, 0);
        chk("t5_cnt", bus.out_err_count, 0);
        chk("t5_dec", bus.out_dec, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t5_no_pulse", bus.out_valid, 0);
        end
        w = fill(4'h1);
        w[4*77 +: 4] = 4'hD;
        e = fill(4'h1);
        e[4*77 +: 4] = 4'h0;
        send(w);
        wait_out(lat);
        result("t5", e, 1);
        step();

        // back-to-back with in_valid held high
        w = fill(4'h2);
        w[4*10 +: 4] = 4'hE;
        e = fill(4'h2);
        e[4*10 +: 4] = 4'h0;
        w2 = fill(4'h8);
        w2[4*299 +: 4] = 4'hD;
        e2 = fill(4'h8);
        e2[4*299 +: 4] = 4'h0;
        bus.in_valid = 1;
        bus.in_bcd = w;
        step();
        chk("t6_first_accept", busy, 1);
        bus.in_bcd = w2;
        wait_out(lat);
        result("t6a", e, 1);
        step();
        chk("t6_gap_ready", bus.in_ready, 1);
        chk("t6_gap_valid", bus.out_valid, 0);
        step();
        chk("t6_second_accept", busy, 1);
        bus.in_valid = 0;
        wait_out(lat);
        result("t6b", e2, 1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
